// File: rtl/iaaa_pkg.sv
// Shared IAAA definitions: opcodes, memory-port commands, fetch FSM states
// and a helper that classifies opcodes that carry an operand word.
package iaaa_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_END   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;
  localparam logic [3:0] OP_STORE = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_MOV   = 4'd12;
  localparam logic [3:0] OP_CMP   = 4'd13;
  localparam logic [3:0] OP_JMP   = 4'd14;
  localparam logic [3:0] OP_JMPZ  = 4'd15;

  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_READ = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OP_REQ,
    S_OP_WAIT,
    S_ISSUE,
    S_HALTED
  } fetch_state_e;

  function automatic logic is_two_word(input logic [3:0] opcode);
    return (opcode == OP_LOAD) || (opcode == OP_JMPZ);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Per-core instruction fetch: walks the PC over one shared-memory read port,
// assembles one/two-word instructions and hands them to the core via valid/ready.
module instr_fetch_unit
  import iaaa_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'd0,
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [1:0]  Control,
  output logic [15:0] InstrAddr,
  input  logic [15:0] InstrIn,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  output logic [15:0] instr,
  output logic [15:0] operand,
  output logic [15:0] instr_pc,
  output logic        halted,
  output logic        fetch_error
);

  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  addr_q, addr_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  operand_q, operand_d;
  logic [15:0]  ipc_q, ipc_d;
  logic         halted_q, halted_d;
  logic         ferr_q, ferr_d;
  logic         pc_ok;
  logic         req_phase;
  logic         accept;

  assign pc_ok     = {1'b0, pc_q} < DEPTH;
  assign req_phase = (state_q == S_REQ) || (state_q == S_OP_REQ);
  assign accept    = (state_q == S_ISSUE) && instr_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    operand_d = operand_q;
    ipc_d     = ipc_q;
    halted_d  = halted_q;
    ferr_d    = ferr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_REQ;
        end
      end
      S_REQ, S_OP_REQ: begin
        addr_d = pc_q;
        // Out-of-range PC halts without ever issuing the read.
        if (!pc_ok) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
          ferr_d   = 1'b1;
        end else begin
          state_d = (state_q == S_REQ) ? S_WAIT : S_OP_WAIT;
        end
      end
      S_WAIT: begin
        instr_d   = InstrIn;
        ipc_d     = pc_q;
        operand_d = '0;
        pc_d      = pc_q + 16'd1;
        state_d   = is_two_word(InstrIn[15:12]) ? S_OP_REQ : S_ISSUE;
      end
      S_OP_WAIT: begin
        operand_d = InstrIn;
        pc_d      = pc_q + 16'd1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (accept) begin
          if (instr_q[15:12] == OP_END) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            if ((instr_q[15:12] == OP_JMPZ) && branch_taken) pc_d = operand_q;
            state_d = S_REQ;
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          halted_d = 1'b0;
          ferr_d   = 1'b0;
          pc_d     = RESET_PC;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      instr_q   <= '0;
      operand_q <= '0;
      ipc_q     <= '0;
      halted_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
      ipc_q     <= ipc_d;
      halted_q  <= halted_d;
      ferr_q    <= ferr_d;
    end
  end

  assign Control     = (req_phase && pc_ok) ? CTRL_READ : CTRL_IDLE;
  assign InstrAddr   = req_phase ? pc_q : addr_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign instr       = instr_q;
  assign operand     = operand_q;
  assign instr_pc    = ipc_q;
  assign halted      = halted_q;
  assign fetch_error = ferr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a program-level model predicts the
// read trace and issued instructions; a negedge monitor checks the DUT against them.
module tb_instr_fetch_unit;
  import iaaa_pkg::*;

  localparam int DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset, start, instr_ready, branch_taken;
  logic [1:0]  Control;
  logic [15:0] InstrAddr, InstrIn, instr, operand, instr_pc;
  logic        instr_valid, halted, fetch_error;

  logic [15:0] mem [0:DEPTH-1];
  logic [15:0] mem_rd = 16'd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  always @(posedge clock)
    if (Control == CTRL_READ)
      mem_rd <= (InstrAddr < 16'(DEPTH)) ? mem[InstrAddr[5:0]] : 16'hDEAD;
  assign InstrIn = mem_rd;

  instr_fetch_unit #(.RESET_PC(16'd0), .MEM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start),
    .Control(Control), .InstrAddr(InstrAddr), .InstrIn(InstrIn),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch_taken(branch_taken),
    .instr(instr), .operand(operand), .instr_pc(instr_pc),
    .halted(halted), .fetch_error(fetch_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [15:0] operand;
    logic [15:0] pc;
    bit          two;
    bit          req_next;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    bit          first;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  bit   bt_arr[$];
  int   stall_arr[$];
  bit   dir_bt[$];
  int   dir_stall[$];
  int   exp_final;   // 0 = truncated, 1 = END, 2 = fault
  int   n_exp;

  // Program-level model: walk the program as the ISA defines it.
  function automatic void build_model(input int n_max);
    int pc = 0;
    exp_q.delete(); rd_q.delete(); bt_arr.delete(); stall_arr.delete();
    exp_final = 0;
    n_exp     = 0;
    for (int k = 0; k < n_max; k++) begin
      exp_t        e;
      rd_t         r;
      logic [15:0] w;
      logic [15:0] op;
      int          nxt;
      bit          bt;
      bit          two;
      if (pc >= DEPTH) begin exp_final = 2; return; end
      w = mem[pc];
      r.addr = 16'(pc); r.first = 1'b1; rd_q.push_back(r);
      two = (w[15:12] == OP_LOAD) || (w[15:12] == OP_JMPZ);
      if (two) begin
        if (pc + 1 >= DEPTH) begin exp_final = 2; return; end
        r.addr = 16'(pc + 1); r.first = 1'b0; rd_q.push_back(r);
        op  = mem[pc + 1];
        nxt = pc + 2;
      end else begin
        op  = 16'd0;
        nxt = pc + 1;
      end
      bt = (dir_bt.size() > 0) ? dir_bt.pop_front() : 1'($urandom % 2);
      if (w[15:12] == OP_JMPZ && bt) nxt = int'(op);
      e.instr = w; e.operand = op; e.pc = 16'(pc); e.two = two;
      e.req_next = (w[15:12] != OP_END) && (nxt < DEPTH);
      exp_q.push_back(e);
      bt_arr.push_back(bt);
      stall_arr.push_back((dir_stall.size() > 0) ? dir_stall.pop_front() : int'($urandom_range(0, 3)));
      n_exp++;
      if (w[15:12] == OP_END) begin exp_final = 1; return; end
      pc = nxt;
    end
    if (pc < DEPTH) begin
      rd_t r2;
      r2.addr = 16'(pc); r2.first = 1'b1; rd_q.push_back(r2);
    end
  endfunction

  // Monitor: samples on the falling edge, the inputs are already settled.
  int          cyc = 0, req_cyc = 0;
  bit          prev_stall = 0, prev_valid = 0, chk_next = 0;
  logic [15:0] p_i, p_o, p_pc;
  exp_t        me;
  rd_t         mr;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 0; prev_valid = 0; chk_next = 0;
    end else begin
      cyc++;
      if (chk_next) begin
        chk("req_after_accept", 32'(Control), 32'(CTRL_READ));
        chk_next = 0;
      end
      if (Control == CTRL_READ) begin
        chk("read_expected", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          mr = rd_q.pop_front();
          chk("read_addr", 32'(InstrAddr), 32'(mr.addr));
          if (mr.first) req_cyc = cyc;
        end
      end
      if (instr_valid) begin
        if (!prev_valid && exp_q.size() > 0)
          chk("latency", 32'(cyc - req_cyc), exp_q[0].two ? 32'd4 : 32'd2);
        if (prev_stall) begin
          chk("stall_instr", 32'(instr), 32'(p_i));
          chk("stall_operand", 32'(operand), 32'(p_o));
          chk("stall_pc", 32'(instr_pc), 32'(p_pc));
          chk("stall_ctrl", 32'(Control), 32'(CTRL_IDLE));
        end
        if (instr_ready) begin
          chk("instr_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("instr", 32'(instr), 32'(me.instr));
            chk("operand", 32'(operand), 32'(me.operand));
            chk("instr_pc", 32'(instr_pc), 32'(me.pc));
            chk_next = me.req_next;
          end
          prev_stall = 0;
        end else begin
          prev_stall = 1; p_i = instr; p_o = operand; p_pc = instr_pc;
        end
      end else begin
        prev_stall = 0;
      end
      prev_valid = instr_valid;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, 32'(Control), 32'd0);
    chk({tag, "_addr"}, 32'(InstrAddr), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_operand"}, 32'(operand), 32'd0);
    chk({tag, "_ipc"}, 32'(instr_pc), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_ferr"}, 32'(fetch_error), 32'd0);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk("start_ctrl", 32'(Control), 32'(CTRL_READ));
    chk("start_addr", 32'(InstrAddr), 32'd0);
    chk("start_halted", 32'(halted), 32'd0);
    chk("start_ferr", 32'(fetch_error), 32'd0);
  endtask

  task automatic run_prog(input int n_max);
    int acc = 0, budget = 0, stall_left, w = 0;
    bit accepting;
    build_model(n_max);
    pulse_start();
    stall_left = stall_arr[0];
    while (acc < n_exp && budget < 2000) begin
      if (instr_valid) begin
        if (stall_left > 0) begin instr_ready = 1'b0; stall_left--; end
        else instr_ready = 1'b1;
        branch_taken = bt_arr[acc];
      end else begin
        instr_ready  = 1'($urandom % 2);
        branch_taken = 1'($urandom % 2);
      end
      start = ($urandom % 8 == 0);
      accepting = instr_valid && instr_ready;
      @(posedge clock); #1;
      if (accepting) begin
        acc++;
        stall_left = (acc < n_exp) ? stall_arr[acc] : 0;
      end
      budget++;
    end
    start = 1'b0;
    instr_ready = 1'b1;
    chk("all_accepted", 32'(acc), 32'(n_exp));
    if (exp_final == 0) begin
      @(posedge clock); #1 reset = 1'b1;
      #1 check_reset("midrun_reset");
      chk("reads_consumed", 32'(rd_q.size()), 32'd0);
      @(posedge clock); #1 reset = 1'b0;
    end else begin
      while (!halted && w < 20) begin @(posedge clock); #1; w++; end
      chk("halted", 32'(halted), 32'd1);
      chk("fetch_error", 32'(fetch_error), (exp_final == 2) ? 32'd1 : 32'd0);
      for (int i = 0; i < 10; i++) begin
        @(posedge clock); #1;
        chk("halt_ctrl", 32'(Control), 32'd0);
        chk("halt_valid", 32'(instr_valid), 32'd0);
      end
      chk("reads_consumed", 32'(rd_q.size()), 32'd0);
    end
    chk("instrs_consumed", 32'(exp_q.size()), 32'd0);
    rd_q.delete(); exp_q.delete();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
  endtask

  task automatic random_mem();
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == OP_END && ($urandom % 3 != 0)) w[15:12] = OP_NOP;
      mem[i] = w;
    end
    for (int i = 0; i < DEPTH - 1; i++)
      if (mem[i][15:12] == OP_JMPZ) mem[i+1] = 16'($urandom_range(0, 68));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    clear_mem();
    repeat (2) @(posedge clock);
    #1 check_reset("reset");
    reset = 1'b0;
    @(posedge clock); #1 check_reset("idle");

    // Standard program: ADD, LOAD, JMPZ chain through 51/39/51/53, END at 61.
    mem[0]  = 16'h207C;
    mem[1]  = 16'h4004; mem[2]  = 16'h0000;
    mem[3]  = 16'hF000; mem[4]  = 16'h0033;
    mem[51] = 16'hF000; mem[52] = 16'h0027;
    mem[39] = 16'hF000; mem[40] = 16'h0033;
    mem[53] = 16'hF000; mem[54] = 16'h003D;
    mem[61] = 16'h1000;
    dir_bt    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    dir_stall = '{0, 5, 0, 0, 0, 0, 0, 0};
    run_prog(40);
    chk("std_len", 32'(n_exp), 32'd8);

    // Running off the end of memory in REQ, then in OP_REQ.
    clear_mem();
    mem[0] = 16'hF000; mem[1] = 16'h003E; mem[62] = 16'h7000; mem[63] = 16'h7000;
    dir_bt = '{1'b1, 1'b0, 1'b0}; dir_stall.delete();
    run_prog(40);
    mem[63] = 16'h4000;
    dir_bt = '{1'b1, 1'b0};
    run_prog(40);

    // Reset while in OP_WAIT: the in-flight operand read must be discarded.
    clear_mem();
    mem[0] = 16'h4123; mem[1] = 16'hBEEF;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    begin
      rd_t r;
      r.addr = 16'd0; r.first = 1'b1; rd_q.push_back(r);
      r.addr = 16'd1; r.first = 1'b0; rd_q.push_back(r);
    end
    pulse_start();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1 check_reset("opwait_reset");
    chk("opwait_reads", 32'(rd_q.size()), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("post_reset_valid", 32'(instr_valid), 32'd0);
      chk("post_reset_operand", 32'(operand), 32'd0);
      chk("post_reset_ctrl", 32'(Control), 32'd0);
    end
    rd_q.delete();

    dir_bt.delete(); dir_stall.delete();
    for (int r = 0; r < 20; r++) begin
      random_mem();
      run_prog(25);
    end

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Per-core instruction fetch initiator for the IAAA multi-core processor. It drives one of the sixteen read ports on the shared instruction memory and walks a program counter. It assembles one-word and two-word instructions (LOAD and JMPZ carry a trailing operand word) and presents each one to its core's decode/execute stage over a valid/ready handshake. JMPZ redirection and END halting are resolved here, using a branch-taken bit that the core returns.

## Interface
Parameters:
- RESET_PC, 16'd0, PC loaded on reset and on every start
- MEM_DEPTH, 64, number of valid instruction-memory words; any PC ≥ MEM_DEPTH is a fault

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin fetching from RESET_PC; accepted only in IDLE or HALTED
- Control  out  2  memory-port command: 2'd1 = read, 2'd0 = idle
- InstrAddr  out  16  memory-port word address
- InstrIn  in  16  memory-port read data; the memory registers it on the clock edge that samples Control==2'd1
- instr_valid  out  1  instr/operand/instr_pc hold a complete instruction
- instr_ready  in  1  core accepts the instruction on a clock edge with instr_valid high
- branch_taken  in  1  sampled at acceptance of a JMPZ; 1 = jump to operand
- instr  out  16  instruction word; opcode [15:12], field A [11:7], field B [6:2]
- operand  out  16  second word for LOAD/JMPZ, otherwise 16'd0
- instr_pc  out  16  address of instr
- halted  out  1  END accepted, or fault
- fetch_error  out  1  PC ≥ MEM_DEPTH at fetch time

## Operation
- FSM states: IDLE, REQ, WAIT, OP_REQ, OP_WAIT, ISSUE, HALTED.
- Control and InstrAddr:
  - Control = 2'd1 only in REQ and OP_REQ; otherwise 2'd0.
  - InstrAddr = pc in REQ and OP_REQ; it holds its last value elsewhere.
- IDLE: on start → REQ, pc = RESET_PC.
- REQ:
  - If pc ≥ MEM_DEPTH → HALTED with fetch_error = 1 and halted = 1; Control stays 2'd0 that cycle.
  - Otherwise → WAIT.
- WAIT: capture InstrIn into instr, set instr_pc = pc, pc = pc+1.
  - Opcode LOAD (4'd4) or JMPZ (4'd15) → OP_REQ.
  - Any other opcode → ISSUE, with operand = 0.
- OP_REQ: same range check as REQ, then → OP_WAIT.
- OP_WAIT: capture InstrIn into operand, pc = pc+1, → ISSUE.
- ISSUE: instr_valid = 1. All outputs are held stable until instr_ready. On acceptance:
  - END (4'd1) → HALTED, halted = 1.
  - JMPZ with branch_taken = 1 → pc = operand, → REQ.
  - Otherwise → REQ with pc unchanged (it already points to the next instruction).
- HALTED: Control = 0 and instr_valid = 0. start clears halted/fetch_error, loads RESET_PC, → REQ.
- pc is 16-bit and wraps from 16'hFFFF to 0. With MEM_DEPTH < 65536 the range check fires before any wrap.
- start is ignored in REQ, WAIT, OP_REQ, OP_WAIT and ISSUE.
- branch_taken is ignored for every opcode except JMPZ.

## Timing
- Reset values: state IDLE, pc RESET_PC, Control 2'd0, InstrAddr 16'd0, instr/operand/instr_pc 16'd0, instr_valid 0, halted 0, fetch_error 0.
- Each memory word costs 2 cycles: REQ (Control asserted), then WAIT (InstrIn valid and captured on the closing edge).
- Instruction latency, from the edge entering REQ:
  - one-word: instr_valid high after 2 edges;
  - two-word: instr_valid high after 4 edges.
- Throughput with instr_ready tied high: 3 cycles per one-word instruction, 5 per two-word.
- Acceptance (valid && ready) and the next REQ are back-to-back: the cycle after acceptance is REQ.
- Reset asserted mid-operation forces the reset values immediately. A read returned later by the memory is discarded; it is never captured because the FSM is not in WAIT or OP_WAIT.

## Structure
- Shared package iaaa_pkg holds:
  - the opcode constants NOP…JMPZ (4-bit);
  - CTRL_IDLE = 2'd0 and CTRL_READ = 2'd1;
  - the fetch-state enum;
  - a function is_two_word(opcode).
- Single module, no sub-module. A memory model that registers its output on Control==2'd1 belongs in the testbench only.

## Test plan
- Reset, then start pulse with the memory loaded from the standard program → Control = 1 / InstrAddr = 0 in the first REQ; instr_valid with instr = 16'h207C, operand = 0, instr_pc = 0 two edges later.
- Next fetch, a two-word LOAD at address 1 → Control pulses at addresses 1 and 2; then instr = 16'h4004, operand = 16'h0000, instr_pc = 1; next REQ at address 3.
- JMPZ at address 51 (16'hF000, operand 16'h0027), accepted with branch_taken = 1 → next InstrAddr = 39. Repeated with branch_taken = 0 → next InstrAddr = 53.
- END at address 61 accepted → halted = 1, Control stays 0 for 10 cycles. A start pulse then produces a REQ at address 0 with halted cleared.
- instr_ready held low for 5 cycles in ISSUE → instr/operand/instr_pc stable and Control = 0 throughout; exactly one REQ follows acceptance.
- MEM_DEPTH = 64 with a program running off address 63 → fetch_error = 1 and halted = 1, with no Control pulse at address 64. Also assert reset during OP_WAIT → all outputs return to their reset values on the same cycle.
